// File: rtl/jam_pkg.sv
// Shared constants, types and FSM encoding for the JAM cost-table responder.
// Optional registered read port is selected by JAM_COST_RD_REG_EN.
package jam_pkg;
  localparam int N_WJ   = 8;
  localparam int COST_W = 7;
  localparam int SUM_W  = 10;

  typedef enum logic {LOAD, READY} state_t;
  typedef logic [COST_W-1:0] cost_t;
  typedef logic [5:0]        wj_idx_t;

  function automatic cost_t cost_min(input cost_t a, input cost_t b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/jam_row_min.sv
// Running row minimum and lower-bound accumulator, one entry per valid cycle.
// Latency: sum updates on the edge that accepts the last entry of a row; no backpressure.
module jam_row_min
  import jam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic             first_i,
  input  logic             last_i,
  input  cost_t            data_i,
  output logic [SUM_W-1:0] sum_o
);
  cost_t            rowmin_q, rowmin_d, row_new;
  logic [SUM_W-1:0] sum_q, sum_d;

  always_comb begin
    row_new  = first_i ? data_i : cost_min(rowmin_q, data_i);
    rowmin_d = rowmin_q;
    sum_d    = sum_q;
    if (valid_i) begin
      rowmin_d = row_new;
      if (last_i) sum_d = sum_q + SUM_W'(row_new);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || clr_i) begin
      rowmin_q <= '0;
      sum_q    <= '0;
    end else begin
      rowmin_q <= rowmin_d;
      sum_q    <= sum_d;
    end
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/jam_cost_table.sv
// 8x8 cost table: streaming load with lower-bound computation, then (W,J) reads.
// Read latency 0 cycles, or 1 cycle when JAM_COST_RD_REG_EN is defined; LdReady drops once full.
module jam_cost_table
  import jam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             LdValid,
  input  cost_t            LdData,
  output logic             LdReady,
  input  logic             Reload,
  input  logic [2:0]       W,
  input  logic [2:0]       J,
  output cost_t            Cost,
  output logic             TableReady,
  output logic [SUM_W-1:0] LowerBound
);
  state_t  state_q, state_d;
  wj_idx_t idx_q, idx_d;
  cost_t   tbl_q [N_WJ*N_WJ];
  logic    xfer;
  wj_idx_t rd_idx;

  // Reload beats a simultaneous transfer, so the entry is dropped.
  assign xfer = (state_q == LOAD) && LdValid && !Reload;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (Reload) begin
      state_d = LOAD;
      idx_d   = '0;
    end else if (xfer) begin
      idx_d = idx_q + 6'd1;
      if (idx_q == 6'd63) state_d = READY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (xfer && !RST) tbl_q[idx_q] <= LdData;
  end

  jam_row_min u_row_min (
    .CLK     (CLK),
    .RST     (RST),
    .clr_i   (Reload),
    .valid_i (xfer),
    .first_i (idx_q[2:0] == 3'd0),
    .last_i  (idx_q[2:0] == 3'd7),
    .data_i  (LdData),
    .sum_o   (LowerBound)
  );

  assign rd_idx     = {W, J};
  assign LdReady    = (state_q == LOAD);
  assign TableReady = (state_q == READY);

`ifdef JAM_COST_RD_REG_EN
  cost_t cost_q;

  always_ff @(posedge CLK) begin
    if (RST) cost_q <= '0;
    else     cost_q <= (state_q == READY) ? tbl_q[rd_idx] : '0;
  end

  // Gate with the live state so a stale value never leaks into LOAD.
  assign Cost = (state_q == READY) ? cost_q : '0;
`else
  assign Cost = (state_q == READY) ? tbl_q[rd_idx] : '0;
`endif
endmodule

// File: tb/tb_jam_cost_table.sv
// Randomized self-checking bench for jam_cost_table against a table-level model.
// Honours JAM_COST_RD_REG_EN for the expected read latency.
module tb_jam_cost_table;
  logic       CLK = 1'b0;
  logic       RST, LdValid, Reload, LdReady, TableReady;
  logic [6:0] LdData, Cost;
  logic [2:0] W, J;
  logic [9:0] LowerBound;

  int vectors    = 0;
  int miscompares = 0;
  int mt [64];

  jam_cost_table dut (
    .CLK(CLK), .RST(RST), .LdValid(LdValid), .LdData(LdData), .LdReady(LdReady),
    .Reload(Reload), .W(W), .J(J), .Cost(Cost), .TableReady(TableReady),
    .LowerBound(LowerBound)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_lb();
    int s = 0;
    for (int w = 0; w < 8; w++) begin
      int m = 1000;
      for (int j = 0; j < 8; j++) if (mt[w*8+j] < m) m = mt[w*8+j];
      s += m;
    end
    return s;
  endfunction

  task automatic load_table(input bit gapped, input string nm);
    int cyc = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge CLK);
      LdValid = 1'b1;
      LdData  = mt[k][6:0];
      if (k == 63) begin
        vectors++;
        if (TableReady !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_early_ready: TableReady=%0b required 0", nm, TableReady);
        end
      end
      @(posedge CLK);
      cyc++;
      if (gapped && k != 63) begin
        @(negedge CLK);
        LdValid = 1'b0;
        @(posedge CLK);
        cyc++;
      end
    end
    @(negedge CLK);
    LdValid = 1'b0;
    vectors++;
    if (TableReady !== 1'b1 || LdReady !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_ready: TableReady=%0b LdReady=%0b required 1/0", nm, TableReady, LdReady);
    end
    vectors++;
    if (int'(LowerBound) != model_lb()) begin
      miscompares++;
      $display("FAIL %s_lb: LowerBound=%0d required %0d", nm, LowerBound, model_lb());
    end
    if (gapped) begin
      vectors++;
      if (cyc != 127) begin
        miscompares++;
        $display("FAIL %s_cycles: ready after %0d cycles required 127", nm, cyc);
      end
    end
  endtask

  task automatic check_read(input int w, input int j, input int exp, input string nm);
    @(negedge CLK);
    W = w[2:0];
    J = j[2:0];
`ifdef JAM_COST_RD_REG_EN
    @(posedge CLK);
    #1;
`else
    #1;
`endif
    vectors++;
    if (int'(Cost) != exp) begin
      miscompares++;
      $display("FAIL %s: W=%0d J=%0d Cost=%0d required %0d", nm, w, j, Cost, exp);
    end
  endtask

  task automatic check_all_reads(input string nm);
    for (int i = 0; i < 64; i++) check_read(i / 8, i % 8, mt[i], nm);
  endtask

  task automatic pulse_reload(input bit with_valid);
    @(negedge CLK);
    Reload  = 1'b1;
    LdValid = with_valid;
    LdData  = 7'd0;
    @(posedge CLK);
    @(negedge CLK);
    Reload  = 1'b0;
    LdValid = 1'b0;
  endtask

  task automatic rand_table(input bit force_zero);
    for (int i = 0; i < 64; i++) mt[i] = $urandom_range(0, 127);
    if (force_zero) mt[$urandom_range(0, 63)] = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1; LdValid = 1'b0; Reload = 1'b0; LdData = '0; W = '0; J = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    vectors++;
    if (LdReady !== 1'b1 || TableReady !== 1'b0 || LowerBound !== 10'd0 || Cost !== 7'd0) begin
      miscompares++;
      $display("FAIL reset: LdReady=%0b TableReady=%0b LB=%0d Cost=%0d required 1/0/0/0",
               LdReady, TableReady, LowerBound, Cost);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 64; i++) mt[i] = i;
    load_table(1'b0, "seq");
    vectors++;
    if (LowerBound !== 10'd224) begin
      miscompares++;
      $display("FAIL seq_lb224: LowerBound=%0d required 224", LowerBound);
    end
    check_read(3, 5, 29, "seq_w3j5");
    check_all_reads("seq_read");
  endtask

  task automatic test_uniform();
    pulse_reload(1'b0);
    for (int i = 0; i < 64; i++) mt[i] = 127;
    load_table(1'b0, "uni");
    vectors++;
    if (LowerBound !== 10'd1016) begin
      miscompares++;
      $display("FAIL uni_lb1016: LowerBound=%0d required 1016", LowerBound);
    end
    check_all_reads("uni_read");
  endtask

  task automatic test_gapped();
    pulse_reload(1'b0);
    for (int i = 0; i < 64; i++) mt[i] = i;
    load_table(1'b1, "gap");
    check_read(3, 5, 29, "gap_w3j5");
  endtask

  task automatic test_reload_load();
    pulse_reload(1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      LdValid = 1'b1;
      LdData  = 7'd0;
      @(posedge CLK);
    end
    // Reload with a simultaneous valid entry: that entry must be dropped.
    pulse_reload(1'b1);
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) mt[w*8+j] = $urandom_range(w + 1, 127);
      mt[w*8 + $urandom_range(0, 7)] = w + 1;
    end
    load_table(1'b0, "rld");
    vectors++;
    if (LowerBound !== 10'd36) begin
      miscompares++;
      $display("FAIL rld_lb36: LowerBound=%0d required 36", LowerBound);
    end
    check_all_reads("rld_read");
  endtask

  task automatic test_reload_ready();
    @(negedge CLK);
    Reload  = 1'b1;
    LdValid = 1'b1;
    LdData  = 7'd5;
    #1;
    vectors++;
    if (LdReady !== 1'b0) begin
      miscompares++;
      $display("FAIL rdy_rld_ldready: LdReady=%0b required 0", LdReady);
    end
    @(posedge CLK);
    @(negedge CLK);
    Reload  = 1'b0;
    LdValid = 1'b0;
    vectors++;
    if (TableReady !== 1'b0 || LdReady !== 1'b1) begin
      miscompares++;
      $display("FAIL rdy_rld_next: TableReady=%0b LdReady=%0b required 0/1", TableReady, LdReady);
    end
    check_read(2, 6, 0, "rdy_rld_cost0");
  endtask

  task automatic test_mid_rst();
    rand_table(1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      LdValid = 1'b1;
      LdData  = mt[k][6:0];
      @(posedge CLK);
    end
    @(negedge CLK);
    LdValid = 1'b0;
    for (int r = 0; r < 4; r++) check_read($urandom_range(0, 7), $urandom_range(0, 7), 0, "load_cost0");
    @(negedge CLK);
    RST = 1'b1;
    LdValid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    LdValid = 1'b0;
    #1;
    vectors++;
    if (LdReady !== 1'b1 || TableReady !== 1'b0 || LowerBound !== 10'd0) begin
      miscompares++;
      $display("FAIL mid_rst: LdReady=%0b TableReady=%0b LB=%0d required 1/0/0",
               LdReady, TableReady, LowerBound);
    end
    // A full table after the reset proves idx restarted at 0.
    rand_table(1'b0);
    load_table(1'b0, "post_rst");
    check_all_reads("post_rst_read");
  endtask

  task automatic test_read_latency();
    int a, b;
    a = 0;
    b = 1;
    for (int i = 1; i < 64; i++) if (mt[i] != mt[a]) b = i;
    @(negedge CLK);
    W = a[5:3]; J = a[2:0];
`ifdef JAM_COST_RD_REG_EN
    @(posedge CLK);
    #1;
    vectors++;
    if (int'(Cost) != mt[a]) begin
      miscompares++;
      $display("FAIL lat_first: Cost=%0d required %0d", Cost, mt[a]);
    end
    W = b[5:3]; J = b[2:0];
    #1;
    vectors++;
    if (int'(Cost) != mt[a]) begin
      miscompares++;
      $display("FAIL lat_hold: Cost=%0d required %0d", Cost, mt[a]);
    end
    @(posedge CLK);
    #1;
    vectors++;
    if (int'(Cost) != mt[b]) begin
      miscompares++;
      $display("FAIL lat_second: Cost=%0d required %0d", Cost, mt[b]);
    end
`else
    #1;
    vectors++;
    if (int'(Cost) != mt[a]) begin
      miscompares++;
      $display("FAIL lat_first: Cost=%0d required %0d", Cost, mt[a]);
    end
    W = b[5:3]; J = b[2:0];
    #1;
    vectors++;
    if (int'(Cost) != mt[b]) begin
      miscompares++;
      $display("FAIL lat_comb: Cost=%0d required %0d", Cost, mt[b]);
    end
`endif
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      pulse_reload(1'b0);
      rand_table(t[0]);
      load_table(t[1], "rnd");
      for (int r = 0; r < 16; r++) begin
        int w = $urandom_range(0, 7);
        int j = $urandom_range(0, 7);
        check_read(w, j, mt[w*8+j], "rnd_read");
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_uniform();
    test_gapped();
    test_reload_load();
    test_reload_ready();
    test_mid_rst();
    test_read_latency();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
